// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Shared opcodes, FSM encoding, instruction fields and decode helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int XLEN = 16;
    localparam int IMM_W = 6;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_BEQ  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // rs2 and imm6 share the low bits of the word; both views are kept here.
    typedef struct packed {
        logic [3:0]       op;
        logic [2:0]       rd;
        logic [2:0]       rs1;
        logic [2:0]       rs2;
        logic [IMM_W-1:0] imm;
    } instr_fields_t;

    function automatic instr_fields_t decode(input logic [XLEN-1:0] word);
        instr_fields_t f;
        f.op  = word[OP_MSB:OP_LSB];
        f.rd  = word[RD_MSB:RD_LSB];
        f.rs1 = word[RS1_MSB:RS1_LSB];
        f.rs2 = word[RS2_MSB:RS2_LSB];
        f.imm = word[IMM_MSB:IMM_LSB];
        return f;
    endfunction

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    function automatic logic is_write_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_ADDI);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_BEQ) || (op == OP_HALT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_alu.sv
// ============================================================================
// Module : cpu_alu
// Combinational ALU for the execute stage; eq drives the BEQ decision.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              eq
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADDI: result = a + imm;
            default: result = '0;
        endcase
    end

    assign eq = (a == b);

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
// ============================================================================
// Module : cpu_ctrl_fsm
// Multi-cycle fetch/decode/execute/writeback control with PC and halt.
// Option : CPU_CTRL_ILLEGAL_TRAP_EN - illegal opcodes halt and raise illegal_op.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int PC_W   = 8,
    parameter int NREG   = 8,
    localparam int RA_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              instr_req,
    output logic [PC_W-1:0]   instr_addr,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr,
    output logic [RA_W-1:0]   rf_raddr1,
    output logic [RA_W-1:0]   rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              halted
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic              illegal_op
`endif
);

    state_t            r_state;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [PC_W-1:0]   r_pc;
    logic              r_branch_taken;
    logic              r_instr_req;
    logic              r_halted;
    logic              r_rf_we;
    logic [RA_W-1:0]   r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic              r_illegal_op;
`endif

    instr_fields_t     w_fields;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_eq;
    logic [PC_W-1:0]   w_pc_seq;
    logic [PC_W-1:0]   w_pc_target;
    logic              w_do_trap;

    assign w_fields = decode(r_instr);
    assign w_imm    = sext_imm(w_fields.imm);

    // Both PC sums are truncated to PC_W, so wrap-around falls out naturally.
    assign w_pc_seq    = r_pc + PC_W'(1);
    assign w_pc_target = w_pc_seq + w_imm[PC_W-1:0];

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    assign w_do_trap = !is_legal_op(w_fields.op);
`else
    assign w_do_trap = 1'b0;
`endif

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (w_fields.op),
        .a      (r_op_a),
        .b      (r_op_b),
        .imm    (w_imm),
        .result (w_alu_result),
        .eq     (w_alu_eq)
    );

    // instr_req is registered, so the first cycle after reset release is a
    // quiet S_FETCH cycle; acceptance is gated on the request actually being up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_FETCH;
            r_instr        <= '0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_pc           <= '0;
            r_branch_taken <= 1'b0;
            r_instr_req    <= 1'b0;
            r_halted       <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            r_illegal_op   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_instr_req && instr_valid) begin
                        r_instr     <= instr;
                        r_instr_req <= 1'b0;
                        r_state     <= S_DECODE;
                    end else begin
                        r_instr_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_op_a  <= rf_rdata1;
                    r_op_b  <= rf_rdata2;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_branch_taken <= (w_fields.op == OP_BEQ) && w_alu_eq;
                    if (w_fields.op == OP_HALT || w_do_trap) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                        r_illegal_op <= w_do_trap;
`endif
                    end else begin
                        r_state <= S_WB;
                        if (is_write_op(w_fields.op)) begin
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= RA_W'(w_fields.rd);
                            r_rf_wdata <= w_alu_result;
                        end
                    end
                end
                S_WB: begin
                    r_rf_we     <= 1'b0;
                    r_pc        <= r_branch_taken ? w_pc_target : w_pc_seq;
                    r_instr_req <= 1'b1;
                    r_state     <= S_FETCH;
                end
                S_HALT: begin
                    r_instr_req <= 1'b0;
                    r_rf_we     <= 1'b0;
                    r_state     <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // BEQ compares R[rd] with R[rs1], so port B reads rd for that opcode.
    assign rf_raddr1  = RA_W'(w_fields.rs1);
    assign rf_raddr2  = (w_fields.op == OP_BEQ) ? RA_W'(w_fields.rd) : RA_W'(w_fields.rs2);

    assign instr_req  = r_instr_req;
    assign instr_addr = r_pc;
    assign pc         = r_pc;
    assign halted     = r_halted;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    assign illegal_op = r_illegal_op;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
// ============================================================================
// Module : tb_cpu_ctrl_fsm
// Directed self-checking bench for cpu_ctrl_fsm with a read-only register model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic [15:0] instr;
    logic [2:0]  rf_raddr1;
    logic [2:0]  rf_raddr2;
    logic [15:0] rf_rdata1;
    logic [15:0] rf_rdata2;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [7:0]  pc;
    logic        halted;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    logic [15:0] regs [8];

    int checks = 0;
    int failures = 0;

    int          we_cycle;
    int          we_pulses;
    logic [2:0]  we_addr;
    logic [15:0] we_data;

    always #5 clk = ~clk;

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    cpu_ctrl_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr       (instr),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pc          (pc),
        .halted      (halted)
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_op  (illegal_op)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Starts on a negedge in S_FETCH with instr_req high; the word is offered
    // for one cycle after `stall` idle cycles, and write pulses are recorded
    // as the negedge index (counted from the start) where rf_we is seen.
    task automatic run_instr(input logic [15:0] w, input int stall);
        we_cycle  = -1;
        we_pulses = 0;
        we_addr   = '0;
        we_data   = '0;
        instr     = w;
        for (int k = 0; k < stall + 8; k++) begin
            instr_valid = (k == stall);
            @(negedge clk);
            if (rf_we === 1'b1) begin
                if (we_cycle < 0) we_cycle = k + 1;
                we_pulses++;
                we_addr = rf_waddr;
                we_data = rf_wdata;
            end
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        int   seen_we;
        int   seen_req;
        int   pc_moved;

        instr_valid = 1'b0;
        instr       = '0;
        for (int i = 0; i < 8; i++) regs[i] = '0;
        regs[1] = 16'd5;
        regs[2] = 16'd7;

        repeat (2) @(negedge clk);
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_rf_we", 32'(rf_we), 32'h0);
        check("reset_halted", 32'(halted), 32'h0);
        check("reset_instr_req", 32'(instr_req), 32'h0);
        check("reset_rf_waddr", 32'(rf_waddr), 32'h0);
        check("reset_rf_wdata", 32'(rf_wdata), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_instr_req", 32'(instr_req), 32'h1);
        check("release_instr_addr", 32'(instr_addr), 32'h0);

        // ADD r3,r1,r2
        run_instr(16'h1650, 0);
        check("add_we_cycle", 32'(we_cycle), 32'd3);
        check("add_we_pulses", 32'(we_pulses), 32'd1);
        check("add_waddr", 32'(we_addr), 32'd3);
        check("add_wdata", 32'(we_data), 32'd12);
        check("add_pc", 32'(pc), 32'd1);

        // ADDI r5,r4,1 with r4=0xFFFF, three stall cycles
        regs[4] = 16'hFFFF;
        run_instr(16'h5B01, 3);
        check("addi_stall_we_cycle", 32'(we_cycle), 32'd6);
        check("addi_we_pulses", 32'(we_pulses), 32'd1);
        check("addi_waddr", 32'(we_addr), 32'd5);
        check("addi_wrap_wdata", 32'(we_data), 32'h0000);
        check("addi_pc", 32'(pc), 32'd2);

        run_instr(16'h2C50, 0);
        check("sub_waddr", 32'(we_addr), 32'd6);
        check("sub_wdata", 32'(we_data), 32'hFFFE);
        run_instr(16'h3E50, 0);
        check("and_wdata", 32'(we_data), 32'h0005);
        run_instr(16'h4050, 0);
        check("or_r0_waddr", 32'(we_addr), 32'd0);
        check("or_r0_wdata", 32'(we_data), 32'h0007);
        check("or_pc", 32'(pc), 32'd5);

        run_instr(16'h0000, 0);
        check("nop_we_pulses", 32'(we_pulses), 32'd0);
        check("nop_pc", 32'(pc), 32'd6);

`ifndef CPU_CTRL_ILLEGAL_TRAP_EN
        run_instr(16'h7000, 0);
        check("illegal_nop_we_pulses", 32'(we_pulses), 32'd0);
        check("illegal_nop_pc", 32'(pc), 32'd7);
        check("illegal_nop_halted", 32'(halted), 32'h0);
        repeat (3) run_instr(16'h0000, 0);
`else
        repeat (4) run_instr(16'h0000, 0);
`endif
        check("pc_before_beq", 32'(pc), 32'd10);

        // BEQ r0,r1,-2 at pc=10: taken -> 9
        regs[0] = 16'd9;
        regs[1] = 16'd9;
        run_instr(16'h607E, 0);
        check("beq_taken_pc", 32'(pc), 32'd9);
        check("beq_taken_we_pulses", 32'(we_pulses), 32'd0);
        run_instr(16'h0000, 0);
        regs[1] = 16'd5;
        run_instr(16'h607E, 0);
        check("beq_not_taken_pc", 32'(pc), 32'd11);
        check("beq_not_taken_we_pulses", 32'(we_pulses), 32'd0);

        // BEQ r0,r1,-13 at pc=11: target wraps to 255, then sequential wrap to 0
        regs[1] = 16'd9;
        run_instr(16'h6073, 0);
        check("beq_wrap_pc", 32'(pc), 32'd255);
        run_instr(16'h0000, 0);
        check("pc_wrap_zero", 32'(pc), 32'd0);
        run_instr(16'h0000, 0);
        check("pc_after_wrap", 32'(pc), 32'd1);

        // Asynchronous reset while in S_EXEC
        regs[1] = 16'd5;
        instr = 16'h1650;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_pc", 32'(pc), 32'h0);
        check("midreset_rf_we", 32'(rf_we), 32'h0);
        check("midreset_rf_wdata", 32'(rf_wdata), 32'h0);
        check("midreset_halted", 32'(halted), 32'h0);
        check("midreset_instr_req", 32'(instr_req), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_release_req", 32'(instr_req), 32'h1);
        check("midreset_release_addr", 32'(instr_addr), 32'h0);
        seen_we = 0;
        repeat (4) begin
            @(negedge clk);
            if (rf_we === 1'b1) seen_we++;
        end
        check("midreset_no_write", 32'(seen_we), 32'd0);

        // HALT at pc=1, then 20 cycles of offered instructions must be ignored
        run_instr(16'h1650, 0);
        check("prehalt_wdata", 32'(we_data), 32'd12);
        run_instr(16'hF000, 0);
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_instr_req", 32'(instr_req), 32'h0);
        check("halt_we_pulses", 32'(we_pulses), 32'd0);
        seen_we = 0;
        seen_req = 0;
        pc_moved = 0;
        instr = 16'h1650;
        instr_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rf_we === 1'b1) seen_we++;
            if (instr_req === 1'b1) seen_req++;
            if (pc !== 8'd1) pc_moved++;
        end
        instr_valid = 1'b0;
        check("halt_frozen_we", 32'(seen_we), 32'd0);
        check("halt_frozen_req", 32'(seen_req), 32'd0);
        check("halt_frozen_pc", 32'(pc_moved), 32'd0);
        check("halt_still_halted", 32'(halted), 32'h1);

        rst_n = 1'b0;
        #1;
        check("halt_reset_halted", 32'(halted), 32'h0);
        check("halt_reset_pc", 32'(pc), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("halt_recover_req", 32'(instr_req), 32'h1);

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        check("trap_reset_illegal_op", 32'(illegal_op), 32'h0);
        run_instr(16'h7000, 0);
        check("trap_halted", 32'(halted), 32'h1);
        check("trap_illegal_op", 32'(illegal_op), 32'h1);
        check("trap_pc", 32'(pc), 32'h0);
        check("trap_we_pulses", 32'(we_pulses), 32'd0);
        check("trap_instr_req", 32'(instr_req), 32'h0);
`else
        run_instr(16'h7000, 0);
        check("illegal_after_reset_pc", 32'(pc), 32'd1);
        check("illegal_after_reset_we", 32'(we_pulses), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control and execute stage for the 16-bit teaching processor, directly upstream of the register storage.
- Fetches a 16-bit instruction over a valid/req handshake and decodes it.
- Reads two operands from the register file and computes the result.
- Drives the register file's write-enable, address and data.
- Maintains the program counter, including branches and halt.

Parameters:
DATA_W, 16, datapath and instruction width
PC_W, 8, program counter width (instruction address space 2^PC_W)
NREG, 8, architectural registers (address width 3)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
instr_req  output  1  fetch request, high while in S_FETCH
instr_addr  output  PC_W  address of requested instruction (equals pc)
instr_valid  input  1  instruction present on instr this cycle
instr  input  DATA_W  instruction word
rf_raddr1  output  3  register read address A (rs1)
rf_raddr2  output  3  register read address B (rs2, or rd for BEQ)
rf_rdata1  input  DATA_W  combinational read data A
rf_rdata2  input  DATA_W  combinational read data B
rf_we  output  1  register write enable, one-cycle pulse
rf_waddr  output  3  write address
rf_wdata  output  DATA_W  write data
pc  output  PC_W  current program counter
halted  output  1  high once HALT executed

Behaviour:
- Reset (asynchronous, rst_n=0), applies immediately, even mid-instruction:
  - state=S_FETCH, pc=0, halted=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, instr_req=0 (asserts once reset is released).
  - Latched instruction and operands cleared.
- Instruction format: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6 (sign-extended to DATA_W).
- Opcodes:
  - 0 NOP
  - 1 ADD: rd=rs1+rs2
  - 2 SUB: rd=rs1-rs2
  - 3 AND
  - 4 OR
  - 5 ADDI: rd=rs1+sext(imm6)
  - 6 BEQ: if R[rd]==R[rs1] then pc=pc+1+sext(imm6)
  - 15 HALT
  - all others illegal (see Optional Feature)
- Arithmetic is modulo 2^DATA_W; carry and overflow are discarded.
- FSM states: S_FETCH -> S_DECODE -> S_EXEC -> S_WB -> S_FETCH; S_HALT is terminal.
- S_FETCH:
  - instr_req=1, instr_addr=pc.
  - Stays in S_FETCH while instr_valid=0.
  - On instr_valid=1, latches instr and moves to S_DECODE.
- S_DECODE:
  - rf_raddr1=rs1; rf_raddr2=rs2, or rd when op=BEQ.
  - Latches rf_rdata1/2 into operand registers at the clock edge.
- S_EXEC:
  - Computes result and branch_taken from the latched operands.
  - op=HALT -> S_HALT; otherwise -> S_WB.
- S_WB:
  - For ADD/SUB/AND/OR/ADDI: rf_we=1 for exactly this cycle, rf_waddr=rd, rf_wdata=result. rf_we=0 in every other state.
  - pc updates to the branch target if taken, else pc+1.
- PC wraps modulo 2^PC_W: pc=2^PC_W-1 with no branch -> 0. Branch targets also wrap.
- Latency: 4 cycles per instruction when instr_valid is high on the first fetch cycle; each stalled fetch cycle adds 1.
- S_HALT: halted=1, instr_req=0, pc frozen. Left only by reset.
- Writes to register 0 are legal; no hardwired zero.
- instr_valid outside S_FETCH is ignored.

Optional Feature:
Macro: CPU_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in S_EXEC goes to S_HALT, with halted=1 and an extra output illegal_op=1 (reset 0).
- Undefined: illegal opcodes execute as NOP (pc+1, no write); the illegal_op port does not exist.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_HALT)
  - FSM state encoding (S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, 3-bit)
  - field bit positions
  - sign-extend function
- Sub-module: cpu_alu, combinational; inputs op, a, b, imm; outputs result and eq.
- The FSM and PC stay in cpu_ctrl_fsm.

Test Plan:
- Reset mid-operation: rst_n=0 asserted during S_EXEC -> outputs clear immediately (pc=0, rf_we=0, halted=0); after release, instr_req=1 and instr_addr=0.
- ADD: R1=5, R2=7, instr=0x1650 (ADD r3,r1,r2), valid on first fetch cycle -> rf_we pulses exactly once, 3 cycles after acceptance, with rf_waddr=3, rf_wdata=12; pc 0->1.
- Wrap and stall: ADDI with rs1=0xFFFF, imm6=1 -> rf_wdata=0x0000. With instr_valid held low 3 cycles before presenting it -> the write occurs 3 cycles later than the unstalled case.
- BEQ: R0=R1=9, BEQ rd=0, rs1=1, imm6=-2 at pc=10 -> pc=9, no rf_we. With R0≠R1 -> pc=11.
- HALT: instr=0xF000 -> halted=1, instr_req=0, pc frozen over 20 cycles; only rst_n recovers.
- Illegal opcode 0x7000 with CPU_CTRL_ILLEGAL_TRAP_EN -> halted=1, illegal_op=1. Without the macro -> pc+1, no write.
